// File: rtl/mipi_dphy_mmcm_drp_pkg.sv
// Shared types and constants for the MIPI D-PHY MMCM DRP reprogramming sequencer.
// Optional macro MIPI_DPHY_MMCM_DRP_VERIFY_EN adds the VF_REQ/VF_WAIT readback states.
package mipi_dphy_mmcm_drp_pkg;

    localparam int N_CFG  = 2;    // 0: 625 MHz (MULT 25), 1: 475 MHz (MULT 19)
    localparam int N_REGS = 8;    // DRP entries per configuration
    localparam int CFG_W  = $clog2(N_CFG);
    localparam int IDX_W  = $clog2(N_REGS);
    localparam int CNT_W  = 16;   // wide enough for the longest lock timeout

    // One DRP register update: bits set in mask keep the MMCM's current value
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        IDLE,
        RST_HOLD,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
`ifdef MIPI_DPHY_MMCM_DRP_VERIFY_EN
        VF_REQ,
        VF_WAIT,
`endif
        RST_TAIL,
        LOCK_WAIT
    } state_t;

    // ClkOut0 reg1/reg2, CLKFBOUT reg1/reg2, lock reg1..3, filter reg1
    localparam drp_entry_t DRP_TABLE [N_CFG][N_REGS] = '{
        '{ {7'h08, 16'hF000, 16'h0ABC}, {7'h09, 16'h8000, 16'h0000},
           {7'h14, 16'h1000, 16'h034C}, {7'h15, 16'h8000, 16'h0080},
           {7'h18, 16'hFC00, 16'h00FA}, {7'h19, 16'h8000, 16'h7C01},
           {7'h1A, 16'h8000, 16'h7DE9}, {7'h4E, 16'h66FF, 16'h9000} },
        '{ {7'h08, 16'hF000, 16'h0E38}, {7'h09, 16'h8000, 16'h0000},
           {7'h14, 16'h1000, 16'h0289}, {7'h15, 16'h8000, 16'h0080},
           {7'h18, 16'hFC00, 16'h0113}, {7'h19, 16'h8000, 16'h7C01},
           {7'h1A, 16'h8000, 16'h7DE9}, {7'h4E, 16'h66FF, 16'h1900} }
    };

    // Read-modify-write merge of the current register value with a table entry
    function automatic logic [15:0] drp_merge(input logic [15:0] old_val, input drp_entry_t e);
        return (old_val & e.mask) | (e.data & ~e.mask);
    endfunction

endpackage

// File: rtl/mipi_dphy_mmcm_drp_seq_if.sv
// MMCME2_ADV DRP port plus MMCM reset/lock, seen from the sequencer (master) and the MMCM (slave).
interface mipi_dphy_mmcm_drp_seq_if;
    logic        mmcm_rst;
    logic [6:0]  mmcm_daddr;
    logic        mmcm_den;
    logic        mmcm_dwe;
    logic [15:0] mmcm_di;
    logic [15:0] mmcm_do;
    logic        mmcm_drdy;
    logic        mmcm_locked;

    modport master (
        output mmcm_rst, mmcm_daddr, mmcm_den, mmcm_dwe, mmcm_di,
        input  mmcm_do, mmcm_drdy, mmcm_locked
    );

    modport slave (
        input  mmcm_rst, mmcm_daddr, mmcm_den, mmcm_dwe, mmcm_di,
        output mmcm_do, mmcm_drdy, mmcm_locked
    );
endinterface

// File: rtl/mipi_dphy_mmcm_drp_rom.sv
// Registered lookup of the DRP configuration table, one cycle latency.
// The table is flattened so the read is a single {cfg, idx} indexed array (N_REGS is a power of two).
module mipi_dphy_mmcm_drp_rom
    import mipi_dphy_mmcm_drp_pkg::*;
(
    input  logic             clk,
    input  logic [CFG_W-1:0] cfg,
    input  logic [IDX_W-1:0] idx,
    output drp_entry_t       entry
);

    drp_entry_t rom_mem [N_CFG*N_REGS];
    drp_entry_t entry_q;

    for (genvar gi = 0; gi < N_CFG*N_REGS; gi++) begin : g_flat
        assign rom_mem[gi] = DRP_TABLE[gi / N_REGS][gi % N_REGS];
    end

    // Registered read so the table maps onto block/distributed ROM
    always_ff @(posedge clk) begin
        entry_q <= rom_mem[{cfg, idx}];
    end

    assign entry = entry_q;

endmodule

// File: rtl/mipi_dphy_mmcm_drp_seq.sv
// Run-time MMCM reprogramming: hold MMCM in reset, read-modify-write every table entry over
// DRP, release reset and wait for lock. Optional macro MIPI_DPHY_MMCM_DRP_VERIFY_EN re-reads
// each written register and flags a mismatch.
// DRP strobes are registered: den is high in the first cycle of the matching *_WAIT state,
// so drdy is ignored while den is still high.
module mipi_dphy_mmcm_drp_seq
    import mipi_dphy_mmcm_drp_pkg::*;
#(
    parameter int RST_CYCLES   = 4,
    parameter int DRP_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CFG_W-1:0]           cfg_sel,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    mipi_dphy_mmcm_drp_seq_if.master   drp
);

    localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRP_LIM  = CNT_W'(DRP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             rst_q, rst_d, den_q, den_d, dwe_q, dwe_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             lock_meta_q, lock_sync_q;
    drp_entry_t       entry;
    logic             drdy_ok, last_idx;

    // Next-state values feed the ROM so the entry is ready when RD_REQ is entered
    mipi_dphy_mmcm_drp_rom u_rom (
        .clk   (clk),
        .cfg   (cfg_d),
        .idx   (idx_d),
        .entry (entry)
    );

    assign drdy_ok  = drp.mmcm_drdy && !den_q;
    assign last_idx = (idx_q == IDX_W'(N_REGS - 1));

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        rst_d   = rst_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        daddr_d = daddr_q;
        di_d    = di_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d   = cfg_sel;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    rst_d   = 1'b1;
                    idx_d   = '0;
                    state_d = RST_HOLD;
                end
            end
            RST_HOLD: begin
                if (cnt_q == RST_LIM) state_d = RD_REQ;
            end
            RD_REQ: begin
                den_d   = 1'b1;
                daddr_d = entry.addr;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (drdy_ok) begin
                    di_d    = drp_merge(drp.mmcm_do, entry);
                    state_d = WR_REQ;
                end else if (cnt_q == DRP_LIM) begin
                    error_d = 1'b1;
                    state_d = RST_TAIL;
                end
            end
            WR_REQ: begin
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                daddr_d = entry.addr;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (drdy_ok) begin
`ifdef MIPI_DPHY_MMCM_DRP_VERIFY_EN
                    state_d = VF_REQ;
`else
                    if (last_idx) begin
                        state_d = RST_TAIL;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = RD_REQ;
                    end
`endif
                end else if (cnt_q == DRP_LIM) begin
                    error_d = 1'b1;
                    state_d = RST_TAIL;
                end
            end
`ifdef MIPI_DPHY_MMCM_DRP_VERIFY_EN
            VF_REQ: begin
                den_d   = 1'b1;
                daddr_d = entry.addr;
                state_d = VF_WAIT;
            end
            VF_WAIT: begin
                if (drdy_ok) begin
                    if (drp.mmcm_do != di_q) begin
                        error_d = 1'b1;
                        state_d = RST_TAIL;
                    end else if (last_idx) begin
                        state_d = RST_TAIL;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = RD_REQ;
                    end
                end else if (cnt_q == DRP_LIM) begin
                    error_d = 1'b1;
                    state_d = RST_TAIL;
                end
            end
`endif
            RST_TAIL: begin
                if (cnt_q == RST_LIM) begin
                    rst_d   = 1'b0;
                    state_d = LOCK_WAIT;
                end
            end
            LOCK_WAIT: begin
                if (lock_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LOCK_LIM) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every timeout/hold count starts from zero on state entry
        if (state_d != state_q) cnt_d = '0;
    end

    // All state, outputs and the two-flop LOCKED synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cfg_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rst_q       <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rst_q       <= rst_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            lock_meta_q <= drp.mmcm_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign drp.mmcm_rst   = rst_q;
    assign drp.mmcm_den   = den_q;
    assign drp.mmcm_dwe   = dwe_q;
    assign drp.mmcm_daddr = daddr_q;
    assign drp.mmcm_di    = di_q;

endmodule

// File: tb/tb_mipi_dphy_mmcm_drp_seq.sv
// Scoreboard bench for mipi_dphy_mmcm_drp_seq with a behavioural MMCM DRP model.
module tb_mipi_dphy_mmcm_drp_seq;
    import mipi_dphy_mmcm_drp_pkg::*;

`ifdef MIPI_DPHY_MMCM_DRP_VERIFY_EN
    localparam int ACC_PER = 3;
`else
    localparam int ACC_PER = 2;
`endif
    localparam int FULL = N_REGS * ACC_PER;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CFG_W-1:0] cfg_sel;
    logic             busy, done, error;

    always #5 clk = ~clk;

    mipi_dphy_mmcm_drp_seq_if drp_if ();

    mipi_dphy_mmcm_drp_seq #(.RST_CYCLES(4), .DRP_TIMEOUT(255), .LOCK_TIMEOUT(100)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cfg_sel (cfg_sel),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .drp     (drp_if)
    );

    typedef struct {
        bit          we;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t        acc_q[$];
    bit          done_exp_q[$];
    int          total = 0, bad = 0;
    int          cyc = 0;
    int          den_cnt = 0, done_cnt = 0;
    int          den_cyc = 0, err_cyc = 0, rst_fall_cyc = 0, done_cyc = 0;
    bit          outstanding = 0;
    logic        prev_err = 1'b0, prev_rst = 1'b0;
    logic [15:0] mem [128];
    int          acc_n = 0, hang_acc = 0;
    bit          corrupt = 0, lock_en = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected DRP traffic for one run, predicted from the model memory as it stands now
    task automatic push_seq(input int cfg, input int n_acc, input bit exp_err);
        logic [15:0] shadow [128];
        drp_entry_t  en;
        logic [15:0] nv;
        int          k;
        shadow = mem;
        k = 0;
        for (int i = 0; i < N_REGS; i++) begin
            en = DRP_TABLE[cfg][i];
            nv = (shadow[en.addr] & en.mask) | (en.data & ~en.mask);
            if (k < n_acc) acc_q.push_back('{we: 1'b0, addr: en.addr, data: 16'h0});
            k++;
            if (k < n_acc) acc_q.push_back('{we: 1'b1, addr: en.addr, data: nv});
            k++;
            shadow[en.addr] = nv;
`ifdef MIPI_DPHY_MMCM_DRP_VERIFY_EN
            if (k < n_acc) acc_q.push_back('{we: 1'b0, addr: en.addr, data: 16'h0});
            k++;
`endif
        end
        done_exp_q.push_back(exp_err);
    endtask

    task automatic do_start(input int cfg);
        @(posedge clk); #1;
        cfg_sel = CFG_W'(cfg);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, done_cnt, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_rst"},   drp_if.mmcm_rst, 0);
        chk({tag, "_den"},   drp_if.mmcm_den, 0);
        chk({tag, "_dwe"},   drp_if.mmcm_dwe, 0);
        chk({tag, "_daddr"}, drp_if.mmcm_daddr, 0);
        chk({tag, "_di"},    drp_if.mmcm_di, 0);
    endtask

    // Behavioural MMCM: 3-cycle drdy latency, optional hang/corruption, lock after reset release
    initial begin
        logic [6:0]  cur_addr, last_addr;
        bit          cur_we, last_we, pend, vf_rd;
        int          lat, lock_cnt;
        drp_if.mmcm_drdy   = 1'b0;
        drp_if.mmcm_do     = 16'h0;
        drp_if.mmcm_locked = 1'b0;
        pend = 0; lat = 0; lock_cnt = 0; last_we = 0; last_addr = '0; vf_rd = 0;
        cur_addr = '0; cur_we = 0;
        forever begin
            @(posedge clk); #1;
            drp_if.mmcm_drdy = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (drp_if.mmcm_den) begin
                acc_n++;
                cur_addr = drp_if.mmcm_daddr;
                cur_we   = drp_if.mmcm_dwe;
                vf_rd    = !cur_we && last_we && (cur_addr == last_addr);
                last_we  = cur_we;
                last_addr = cur_addr;
                pend     = (acc_n != hang_acc);
                lat      = 3;
                if (cur_we) mem[cur_addr] = drp_if.mmcm_di;
            end else if (pend) begin
                lat--;
                if (lat == 0) begin
                    pend = 0;
                    drp_if.mmcm_drdy = 1'b1;
                    drp_if.mmcm_do   = mem[cur_addr] ^ ((corrupt && vf_rd) ? 16'h0001 : 16'h0000);
                end
            end
            if (reset || drp_if.mmcm_rst) begin
                lock_cnt = 0;
                drp_if.mmcm_locked = 1'b0;
            end else if (lock_en) begin
                if (lock_cnt < 10) lock_cnt++;
                else drp_if.mmcm_locked = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every DRP access and every done pulse
    initial begin
        acc_t e;
        bit   de;
        forever begin
            @(negedge clk);
            if (reset) begin
                outstanding = 0;
                prev_err = 1'b0;
                prev_rst = 1'b0;
            end else begin
                if (drp_if.mmcm_den) begin
                    den_cnt++;
                    den_cyc = cyc;
                    $display("acc %0d cyc=%0d we=%0b addr=%02h di=%04h", den_cnt, cyc,
                             drp_if.mmcm_dwe, drp_if.mmcm_daddr, drp_if.mmcm_di);
                    chk("den_while_pending", outstanding, 0);
                    chk("rst_during_access", drp_if.mmcm_rst, 1);
                    outstanding = 1;
                    if (acc_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_den: got den at addr %02h want none", drp_if.mmcm_daddr);
                    end else begin
                        e = acc_q.pop_front();
                        chk("acc_we", drp_if.mmcm_dwe, e.we);
                        chk("acc_addr", drp_if.mmcm_daddr, e.addr);
                        if (e.we) chk("acc_di", drp_if.mmcm_di, e.data);
                    end
                end
                if (drp_if.mmcm_drdy) outstanding = 0;
                if (error && !prev_err) err_cyc = cyc;
                if (!drp_if.mmcm_rst && prev_rst) rst_fall_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    outstanding = 0;
                    $display("done %0d cyc=%0d error=%0b", done_cnt, cyc, error);
                    if (done_exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got done want none");
                    end else begin
                        de = done_exp_q.pop_front();
                        chk("done_error", error, de);
                        chk("done_busy", busy, 0);
                    end
                end
                prev_err = error;
                prev_rst = drp_if.mmcm_rst;
            end
        end
    end

    initial begin
        int base, n;
        reset = 1'b1; start = 1'b0; cfg_sel = '0;
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 257) ^ 16'h5A5A;
        mem[8] = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // 1/2: full cfg 0 run, RMW of 0x08 gives 0x1ABC
        acc_n = 0; base = den_cnt;
        push_seq(0, FULL, 0);
        do_start(0);
        chk("t1_busy", busy, 1);
        chk("t1_rst", drp_if.mmcm_rst, 1);
        wait_done(1, 3000, "t1_done");
        chk("t1_mem08", mem[8], 16'h1ABC);
        chk("t2_den_count", den_cnt - base, FULL);
        chk("t2_queue_empty", acc_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_single_done", done_cnt, 1);

        // 3: third access never answered -> DRP timeout after 255 cycles
        acc_n = 0; base = den_cnt; hang_acc = 3;
        push_seq(1, 3, 1);
        do_start(1);
        wait_done(2, 3000, "t3_done");
        chk("t3_timeout_cycles", err_cyc - den_cyc, 255);
        chk("t3_den_count", den_cnt - base, 3);
        chk("t3_rst_released", drp_if.mmcm_rst, 0);
        hang_acc = 0;

        // 4: no lock -> timeout 100 cycles after mmcm_rst falls
        lock_en = 0; acc_n = 0;
        push_seq(0, FULL, 1);
        do_start(0);
        wait_done(3, 3000, "t4_done");
        chk("t4_lock_cycles", done_cyc - rst_fall_cyc, 100);
        chk("t4_err_with_done", err_cyc, done_cyc);
        chk("t4_error", error, 1);
        lock_en = 1;

        // 5: start while busy ignored, then reset in the middle of a read wait
        acc_n = 0; base = den_cnt;
        push_seq(0, FULL, 0);
        do_start(0);
        repeat (2) @(posedge clk);
        #1;
        cfg_sel = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (den_cnt - base < 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reached_rd", den_cnt - base, 3);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk_all_zero("t5_reset");
        acc_q.delete();
        done_exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        acc_n = 0; base = den_cnt;
        push_seq(1, FULL, 0);
        do_start(1);
        wait_done(4, 3000, "t5_done");
        chk("t5_den_count", den_cnt - base, FULL);
        chk("t5_queue_empty", acc_q.size(), 0);
        chk("t5_error", error, 0);

`ifdef MIPI_DPHY_MMCM_DRP_VERIFY_EN
        // 6: corrupted readback of the first write -> error
        corrupt = 1; acc_n = 0; base = den_cnt;
        push_seq(0, 3, 1);
        do_start(0);
        wait_done(5, 3000, "t6_done");
        chk("t6_den_count", den_cnt - base, 3);
        chk("t6_error", error, 1);
        corrupt = 0;
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
